// File: rtl/ec_pkg.sv
// Shared evolutionary-core constants: population geometry, LFSR definition
// and the selection FSM state encoding.
package ec_pkg;

    localparam int unsigned DefPopSize  = 50;
    localparam int unsigned DefFitWidth = 10;
    localparam int unsigned DefIdxWidth = 6;
    localparam int unsigned DefTourSize = 2;

    localparam int unsigned LfsrWidth = 16;
    // Taps 16,14,13,11 expressed as a mask over state bits 15,13,12,10.
    localparam logic [LfsrWidth-1:0] LfsrTaps = 16'hB400;
    localparam logic [LfsrWidth-1:0] LfsrSeed = 16'hACE1;

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StSelect  = 2'd1,
        StFinish  = 2'd2
    } sel_state_e;

endpackage

// File: rtl/tournament_select_if.sv
// Fitness-capture and parent-handshake bundle between the evaluation stage,
// the tournament selector and the crossover stage.
interface tournament_select_if
    import ec_pkg::*;
#(
    parameter int unsigned FIT_WIDTH = DefFitWidth,
    parameter int unsigned IDX_WIDTH = DefIdxWidth
);
    logic                 fit_valid_i;
    logic [FIT_WIDTH-1:0] fit_i;
    logic [IDX_WIDTH-1:0] fit_idx_i;
    logic                 fit_done_i;
    logic                 parent_valid_o;
    logic                 parent_ready_i;
    logic [IDX_WIDTH-1:0] parent_idx_o;
    logic [IDX_WIDTH-1:0] best_idx_o;
    logic [FIT_WIDTH-1:0] best_fit_o;
    logic                 sel_done_o;
    logic                 busy_o;
    logic                 overrun_o;

    modport master (
        output fit_valid_i, fit_i, fit_idx_i, fit_done_i, parent_ready_i,
        input  parent_valid_o, parent_idx_o, best_idx_o, best_fit_o,
        input  sel_done_o, busy_o, overrun_o
    );

    modport slave (
        input  fit_valid_i, fit_i, fit_idx_i, fit_done_i, parent_ready_i,
        output parent_valid_o, parent_idx_o, best_idx_o, best_fit_o,
        output sel_done_o, busy_o, overrun_o
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0; holds while en is low.
module lfsr16
    import ec_pkg::*;
#(
    parameter logic [LfsrWidth-1:0] SEED = LfsrSeed
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [LfsrWidth-1:0] state
);
    logic [LfsrWidth-1:0] state_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else if (en) begin
            state_q <= {state_q[LfsrWidth-2:0], ^(state_q & LfsrTaps)};
        end
    end

    assign state = state_q;
endmodule

// File: rtl/tournament_select.sv
// Captures per-individual energies, tracks the generation best, then issues
// POP_SIZE LFSR-driven tournament winners over a valid/ready handshake.
module tournament_select
    import ec_pkg::*;
#(
    parameter int unsigned          POP_SIZE  = DefPopSize,
    parameter int unsigned          FIT_WIDTH = DefFitWidth,
    parameter int unsigned          IDX_WIDTH = DefIdxWidth,
    parameter int unsigned          TOUR_SIZE = DefTourSize,
    parameter logic [LfsrWidth-1:0] LFSR_SEED = LfsrSeed
) (
    input logic                clk_i,
    input logic                rst_n,
    tournament_select_if.slave bus
);
    localparam int unsigned ParW  = $clog2(POP_SIZE + 1);
    localparam int unsigned DrawW = $clog2(TOUR_SIZE + 1);
    localparam logic [IDX_WIDTH:0] PopLim = (IDX_WIDTH + 1)'(POP_SIZE);

    sel_state_e state_q, state_d;
    logic [FIT_WIDTH-1:0] fit_rf [POP_SIZE];
    logic                 rf_we;
    logic [LfsrWidth-1:0] lfsr;
    logic                 lfsr_en;
    logic [IDX_WIDTH-1:0] cand;
    logic [FIT_WIDTH-1:0] cand_fit;
    logic                 cand_ok, fit_in_range;
    logic [DrawW-1:0]     draw_q, draw_d;
    logic [ParW-1:0]      par_q, par_d;
    logic [IDX_WIDTH-1:0] win_idx_q, win_idx_d, pidx_q, pidx_d, best_idx_q, best_idx_d;
    logic [FIT_WIDTH-1:0] win_fit_q, win_fit_d, best_fit_q, best_fit_d;
    logic                 pv_q, pv_d, overrun_q, overrun_d;
    logic                 unused_lfsr;

    // The LFSR only freezes while a parent is offered and not yet taken.
    assign lfsr_en = (state_q == StSelect) && !(pv_q && !bus.parent_ready_i);

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .state (lfsr)
    );

    assign cand         = lfsr[IDX_WIDTH-1:0];
    assign unused_lfsr  = ^lfsr[LfsrWidth-1:IDX_WIDTH];
    assign cand_ok      = {1'b0, cand} < PopLim;
    assign cand_fit     = fit_rf[cand];
    assign fit_in_range = {1'b0, bus.fit_idx_i} < PopLim;

    always_comb begin
        state_d    = state_q;
        draw_d     = draw_q;
        par_d      = par_q;
        win_idx_d  = win_idx_q;
        win_fit_d  = win_fit_q;
        pv_d       = pv_q;
        pidx_d     = pidx_q;
        best_idx_d = best_idx_q;
        best_fit_d = best_fit_q;
        overrun_d  = overrun_q;
        rf_we      = 1'b0;
        unique case (state_q)
            StCollect: begin
                if (bus.fit_valid_i && fit_in_range) begin
                    rf_we = 1'b1;
                    if (bus.fit_i < best_fit_q) begin
                        best_fit_d = bus.fit_i;
                        best_idx_d = bus.fit_idx_i;
                    end
                end
                if (bus.fit_done_i) state_d = StSelect;
            end
            StSelect: begin
                if (bus.fit_valid_i) overrun_d = 1'b1;
                if (pv_q) begin
                    if (bus.parent_ready_i) begin
                        pv_d = 1'b0;
                        if (par_q == ParW'(POP_SIZE - 1)) begin
                            par_d   = '0;
                            state_d = StFinish;
                        end else begin
                            par_d = par_q + 1'b1;
                        end
                    end
                end else if (cand_ok) begin
                    // Strict compare: on a tie the earlier draw keeps the win.
                    if (draw_q == '0 || cand_fit < win_fit_q) begin
                        win_idx_d = cand;
                        win_fit_d = cand_fit;
                    end
                    if (draw_q == DrawW'(TOUR_SIZE - 1)) begin
                        draw_d = '0;
                        pv_d   = 1'b1;
                        pidx_d = win_idx_d;
                    end else begin
                        draw_d = draw_q + 1'b1;
                    end
                end
            end
            StFinish: begin
                if (bus.fit_valid_i) overrun_d = 1'b1;
                best_fit_d = '1;
                best_idx_d = '0;
                state_d    = StCollect;
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rf_we) fit_rf[bus.fit_idx_i] <= bus.fit_i;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StCollect;
            draw_q     <= '0;
            par_q      <= '0;
            win_idx_q  <= '0;
            win_fit_q  <= '0;
            pv_q       <= 1'b0;
            pidx_q     <= '0;
            best_idx_q <= '0;
            best_fit_q <= '1;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            draw_q     <= draw_d;
            par_q      <= par_d;
            win_idx_q  <= win_idx_d;
            win_fit_q  <= win_fit_d;
            pv_q       <= pv_d;
            pidx_q     <= pidx_d;
            best_idx_q <= best_idx_d;
            best_fit_q <= best_fit_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.parent_valid_o = pv_q;
    assign bus.parent_idx_o   = pidx_q;
    assign bus.best_idx_o     = best_idx_q;
    assign bus.best_fit_o     = best_fit_q;
    assign bus.sel_done_o     = (state_q == StFinish);
    assign bus.busy_o         = (state_q != StCollect);
    assign bus.overrun_o      = overrun_q;
endmodule

// File: tb/tb_tournament_select.sv
// Bench for tournament_select: table-driven collect checks plus full selection
// generations compared against a tournament-level reference model.
module tb_tournament_select;
    localparam int POP  = 50;
    localparam int TOUR = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tournament_select_if bus ();

    tournament_select dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0]  m_fit [POP];
    logic [9:0]  m_best_fit = 10'h3FF;
    logic [5:0]  m_best_idx = 6'd0;
    logic [15:0] m_lfsr = SEED;

    typedef struct packed {
        bit         v;
        logic [5:0] idx;
        logic [9:0] fit;
        logic [5:0] e_idx;
        logic [9:0] e_fit;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // One tournament: draw TOUR in-range candidates, keep the strictly fittest.
    task automatic model_tournament(output logic [5:0] w, output logic [15:0] l);
        int acc = 0;
        logic [5:0] c;
        logic [9:0] wf = '0;
        w = '0;
        while (acc < TOUR) begin
            c = m_lfsr[5:0];
            m_lfsr = step(m_lfsr);
            if (c < POP) begin
                if (acc == 0 || m_fit[c] < wf) begin
                    w  = c;
                    wf = m_fit[c];
                end
                acc++;
            end
        end
        l = m_lfsr;
    endtask

    task automatic wr(input logic [5:0] idx, input logic [9:0] fit, input bit done);
        @(negedge clk);
        bus.fit_valid_i = 1'b1;
        bus.fit_idx_i   = idx;
        bus.fit_i       = fit;
        bus.fit_done_i  = done;
        @(posedge clk);
        #1;
        bus.fit_valid_i = 1'b0;
        bus.fit_done_i  = 1'b0;
        if (idx < POP) begin
            m_fit[idx] = fit;
            if (fit < m_best_fit) begin
                m_best_fit = fit;
                m_best_idx = idx;
            end
        end
    endtask

    task automatic run_select(input bit rnd_ready, input int stall_at, input bit inject);
        int got = 0, cyc = 0, done_cnt = 0, hold = 0, since = 0;
        bit have = 0;
        logic [5:0] exp_w;
        logic [15:0] exp_l;
        while (got < POP && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (bus.sel_done_o) done_cnt++;
            if (inject && cyc == 20) begin
                bus.fit_valid_i = 1'b1;
                bus.fit_idx_i   = 6'd0;
                bus.fit_i       = 10'd0;
            end else begin
                bus.fit_valid_i = 1'b0;
            end
            if (bus.parent_valid_o) begin
                if (!have) begin
                    if (got > 0) check("valid_gap", 32'(since >= TOUR), 1);
                    model_tournament(exp_w, exp_l);
                    have = 1;
                    hold = (got == stall_at) ? 5 : 0;
                end
                check("parent_idx", bus.parent_idx_o, exp_w);
                check("lfsr_hold", dut.u_lfsr.state, exp_l);
                if (hold > 0) begin
                    bus.parent_ready_i = 1'b0;
                    hold--;
                end else begin
                    bus.parent_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (bus.parent_ready_i) begin
                    got++;
                    have = 0;
                    since = 0;
                    m_lfsr = step(m_lfsr);
                end
            end else begin
                since++;
                bus.parent_ready_i = 1'($urandom_range(0, 1));
            end
        end
        check("select_count", got, POP);
        @(negedge clk);
        bus.fit_valid_i = 1'b0;
        bus.parent_ready_i = 1'b0;
        if (bus.sel_done_o) done_cnt++;
        check("finish_busy", bus.busy_o, 1);
        @(negedge clk);
        if (bus.sel_done_o) done_cnt++;
        check("sel_done_pulses", done_cnt, 1);
        check("idle_busy", bus.busy_o, 0);
        check("best_fit_clr", bus.best_fit_o, 10'h3FF);
        check("best_idx_clr", bus.best_idx_o, 0);
        m_best_fit = 10'h3FF;
        m_best_idx = 6'd0;
        if (inject) check("overrun_sticky", bus.overrun_o, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pv"}, bus.parent_valid_o, 0);
        check({tag, "_pidx"}, bus.parent_idx_o, 0);
        check({tag, "_bidx"}, bus.best_idx_o, 0);
        check({tag, "_bfit"}, bus.best_fit_o, 10'h3FF);
        check({tag, "_done"}, bus.sel_done_o, 0);
        check({tag, "_busy"}, bus.busy_o, 0);
        check({tag, "_ovr"}, bus.overrun_o, 0);
        check({tag, "_lfsr"}, dut.u_lfsr.state, SEED);
    endtask

    initial begin
        int order [POP];
        int j, t;
        bus.fit_valid_i = 1'b0;
        bus.fit_i = '0;
        bus.fit_idx_i = '0;
        bus.fit_done_i = 1'b0;
        bus.parent_ready_i = 1'b0;

        tbl[0] = '{1'b1, 6'd3,  10'd5, 6'd3, 10'd5};
        tbl[1] = '{1'b1, 6'd7,  10'd5, 6'd3, 10'd5};
        tbl[2] = '{1'b1, 6'd55, 10'd0, 6'd3, 10'd5};
        tbl[3] = '{1'b0, 6'd2,  10'd0, 6'd3, 10'd5};
        tbl[4] = '{1'b1, 6'd8,  10'd6, 6'd3, 10'd5};
        tbl[5] = '{1'b1, 6'd63, 10'd1, 6'd3, 10'd5};

        // Reset asserted between clock edges must act immediately.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Generation A: descending energies, best is the last written.
        for (int i = 0; i < POP; i++) wr(6'(i), 10'(100 - i), i == POP - 1);
        check("genA_best_idx", bus.best_idx_o, 49);
        check("genA_best_fit", bus.best_fit_o, 51);
        check("genA_busy", bus.busy_o, 1);
        run_select(1'b0, -1, 1'b0);

        // Table: ties, out-of-range indices and idle cycles in COLLECT.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].v) wr(tbl[i].idx, tbl[i].fit, 1'b0);
            else begin
                @(posedge clk);
                #1;
            end
            check("tbl_best_idx", bus.best_idx_o, tbl[i].e_idx);
            check("tbl_best_fit", bus.best_fit_o, tbl[i].e_fit);
            check("tbl_overrun", bus.overrun_o, 0);
            check("tbl_busy", bus.busy_o, 0);
        end
        for (int i = 0; i < POP; i++)
            if (i != 3 && i != 7) wr(6'(i), 10'd20, i == POP - 1);
        check("tie_best_idx", bus.best_idx_o, 3);
        check("tie_best_fit", bus.best_fit_o, 5);
        run_select(1'b1, -1, 1'b0);

        // Generation B: one dominant individual, with a 5-cycle backpressure hold.
        for (int i = 0; i < POP; i++) wr(6'(i), (i == 10) ? 10'd0 : 10'd9, i == POP - 1);
        check("genB_best_idx", bus.best_idx_o, 10);
        check("genB_best_fit", bus.best_fit_o, 0);
        run_select(1'b0, 7, 1'b0);

        // Generation C: shuffled arrival, small-range energies, overrun during SELECT.
        for (int i = 0; i < POP; i++) order[i] = i;
        for (int i = POP - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        wr(6'd60, 10'd0, 1'b0);
        for (int i = 0; i < POP; i++)
            wr(6'(order[i]), 10'($urandom_range(0, 15)), i == POP - 1);
        check("genC_best_idx", bus.best_idx_o, m_best_idx);
        check("genC_best_fit", bus.best_fit_o, m_best_fit);
        check("genC_overrun0", bus.overrun_o, 0);
        run_select(1'b1, 20, 1'b1);

        // Abort mid-SELECT via asynchronous reset.
        for (int i = 0; i < 5; i++) wr(6'(i), 10'($urandom_range(0, 1023)), i == 4);
        bus.parent_ready_i = 1'b1;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst1");
        @(negedge clk);
        bus.parent_ready_i = 1'b0;
        rst_n = 1'b1;
        m_lfsr = SEED;
        m_best_fit = 10'h3FF;
        m_best_idx = 6'd0;

        // Generation E: parents after the abort must follow the reseeded LFSR.
        for (int i = 0; i < POP; i++)
            wr(6'(i), (i == 20) ? 10'd1 : 10'($urandom_range(2, 1023)), i == POP - 1);
        check("genE_best_idx", bus.best_idx_o, 20);
        run_select(1'b1, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tournament_select.md
Name: tournament_select

Overview:
- Sits directly downstream of the fitness evaluation stage.
- Captures one total-energy value per individual into a fitness register file and tracks the generation's best (minimum-energy) individual.
- After the generation completes, runs POP_SIZE deterministic LFSR-driven tournaments and hands the winning parent indices to the crossover stage over a valid/ready handshake.

Parameters:
POP_SIZE, 50, individuals per generation
FIT_WIDTH, 10, width of one energy value (lower is fitter)
IDX_WIDTH, 6, individual index width; must satisfy 2**IDX_WIDTH >= POP_SIZE
TOUR_SIZE, 2, accepted draws per tournament (>=1)
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk_i  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fit_valid_i  in  1  fitness write strobe from evaluation stage
fit_i  in  FIT_WIDTH  total energy of the individual
fit_idx_i  in  IDX_WIDTH  individual index of fit_i
fit_done_i  in  1  last individual of the generation (may coincide with fit_valid_i)
parent_valid_o  out  1  parent_idx_o is valid
parent_ready_i  in  1  consumer accepts the parent
parent_idx_o  out  IDX_WIDTH  tournament winner index
best_idx_o  out  IDX_WIDTH  index of the current best individual
best_fit_o  out  FIT_WIDTH  energy of the current best individual
sel_done_o  out  1  one-cycle pulse after the final parent is accepted
busy_o  out  1  high in SELECT and FINISH
overrun_o  out  1  sticky error flag

Behaviour:
- Reset values: parent_valid_o=0, parent_idx_o=0, best_idx_o=0, best_fit_o=all-ones, sel_done_o=0, busy_o=0, overrun_o=0, LFSR=LFSR_SEED, FSM=COLLECT. The fitness register file is not reset.
- States: COLLECT, SELECT, FINISH. Reset mid-operation aborts immediately and returns everything to the reset values.
- COLLECT:
  - On fit_valid_i with fit_idx_i<POP_SIZE: write fit_rf[fit_idx_i]=fit_i.
  - If fit_i < best_fit_o (strict less-than), update best_fit_o/best_idx_o on the next edge. Ties keep the earlier arrival.
  - fit_idx_i>=POP_SIZE: no write, no best update, no error.
  - fit_done_i: the same-cycle write is included; next state is SELECT.
  - No count check: missing individuals keep stale fit_rf contents.
- SELECT:
  - The LFSR (16-bit Fibonacci, taps 16,14,13,11, shifts left, feedback into bit 0) advances every cycle except while parent_valid_o=1 and parent_ready_i=0.
  - Candidate = LFSR[IDX_WIDTH-1:0] sampled before the shift. If candidate>=POP_SIZE it is rejected, which consumes the cycle but no draw.
  - First accepted draw of a tournament loads the winner.
  - Each later accepted draw replaces the winner only if fit_rf[cand] < winner fitness (strict). Ties keep the earlier draw.
  - Duplicate draws are allowed.
  - After TOUR_SIZE accepted draws, parent_valid_o=1 next cycle with parent_idx_o=winner. These are held stable until the handshake completes (valid&ready).
  - After a handshake, the next tournament starts the following cycle; parent_valid_o drops for at least TOUR_SIZE cycles.
- Parent counter: counts accepted handshakes. When the POP_SIZE-th handshake completes, go to FINISH.
- FINISH (one cycle):
  - sel_done_o=1.
  - best_fit_o resets to all-ones and best_idx_o resets to 0.
  - Return to COLLECT.
  - LFSR is not reseeded between generations.
- fit_valid_i in SELECT or FINISH: the write is dropped and overrun_o is set. overrun_o clears only on reset.
- Minimum SELECT duration: POP_SIZE*(TOUR_SIZE+1) cycles with parent_ready_i tied high and no rejections.

Decomposition:
- Shared package ec_pkg: POP_SIZE, FIT_WIDTH, IDX_WIDTH, TOUR_SIZE defaults; LFSR width, taps and seed; FSM state encoding.
- Sub-module lfsr16 (enable input, seed parameter, 16-bit state output), reused later by crossover/mutation.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs at reset values immediately, with no clock edge; busy_o=0.
- Collect: write idx 0..49 with fit=100-idx, fit_done_i on idx 49 -> best_idx_o=49 and best_fit_o=51 one cycle after the last write; busy_o=1 the cycle after.
- Tie: fit[3]=5 then fit[7]=5, all others 20 -> best_idx_o=3.
- Tournament: fit[10]=0, all others 9, parent_ready_i=1 -> 50 parents match a reference model. That model uses the same LFSR and rejection rule (seed 16'hACE1); every tournament that draws 10 returns 10. sel_done_o pulses exactly once.
- Backpressure: parent_ready_i=0 for 5 cycles with a parent valid -> parent_idx_o stable and LFSR frozen. The next parents still match the model.
- Errors and abort:
  - fit_idx_i=55 in COLLECT -> ignored, overrun_o=0.
  - fit_valid_i during SELECT -> overrun_o=1 and sticky.
  - rst_n low mid-SELECT -> returns to COLLECT with LFSR=16'hACE1.
